// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to NCH output channels, each with a
// one-entry holding register. Words whose in_sel is outside the channel range
// are accepted, discarded and counted in a saturating 8-bit drop counter.
// Optional broadcast mode is built when STREAM_DEMUX_BCAST_EN is defined: with
// in_bcast high, a word is written to every channel at once. When the macro is
// undefined, in_bcast is ignored but the port is kept.
module stream_demux #(
   parameter int unsigned DW   = 8,
   parameter int unsigned NCH  = 8,
   parameter int unsigned SELW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   input  logic [SELW-1:0]   in_sel,
   input  logic              in_bcast,
   output logic [NCH-1:0]    out_valid,
   input  logic [NCH-1:0]    out_ready,
   output logic [NCH*DW-1:0] out_data,
   output logic [7:0]        drop_cnt
);

   logic [NCH-1:0] valid_q, valid_d;
   logic [DW-1:0]  data_q [NCH];
   logic [DW-1:0]  data_d [NCH];
   logic [7:0]     drop_q, drop_d;

   logic [NCH-1:0] slot_free;
   logic [NCH-1:0] sel_hit;
   logic [NCH-1:0] load;
   logic           sel_in_range;
   logic           accept;
   logic           bcast;

`ifdef STREAM_DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   // Port stays present but has no effect.
   assign bcast = 1'b0 & in_bcast;
`endif

   // Decode the target channel and work out readiness for this cycle.
   always_comb begin
      sel_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         sel_hit[i] = (in_sel == SELW'(i));
      end
      sel_in_range = |sel_hit;
      // A slot can take a word if it is empty or is being drained this cycle.
      slot_free = ~valid_q | out_ready;

      if (rst) begin
         in_ready = 1'b0;
      end else if (bcast) begin
         in_ready = &slot_free;
      end else if (sel_in_range) begin
         in_ready = |(sel_hit & slot_free);
      end else begin
         // Out-of-range words are always swallowed.
         in_ready = 1'b1;
      end

      accept = in_valid & in_ready;
      load   = accept ? (bcast ? {NCH{1'b1}} : sel_hit) : '0;
   end

   // Next state of the holding registers and the drop counter.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < NCH; i++) begin
         data_d[i] = data_q[i];
         if (load[i]) begin
            valid_d[i] = 1'b1;
            data_d[i]  = in_data;
         end else if (valid_q[i] && out_ready[i]) begin
            valid_d[i] = 1'b0;
         end
      end

      drop_d = drop_q;
      if (accept && !bcast && !sel_in_range && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         drop_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         drop_q  <= drop_d;
         for (int i = 0; i < NCH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   // Pack per-channel holding registers onto the output bus.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < NCH; i++) begin
         out_data[i*DW +: DW] = data_q[i];
      end
   end

   assign out_valid = valid_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: per-channel queue scoreboard with directed steps,
// plus a second 6-channel instance for drop-counter saturation.
module tb_stream_demux;

   localparam int unsigned DW   = 8;
   localparam int unsigned NCH  = 8;
   localparam int unsigned SELW = 4;
`ifdef STREAM_DEMUX_BCAST_EN
   localparam bit BcastEn = 1'b1;
`else
   localparam bit BcastEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic [SELW-1:0]   in_sel;
   logic              in_bcast;
   logic [NCH-1:0]    out_valid;
   logic [NCH-1:0]    out_ready;
   logic [NCH*DW-1:0] out_data;
   logic [7:0]        drop_cnt;

   logic              in_valid6;
   logic              in_ready6;
   logic [7:0]        in_data6;
   logic [2:0]        in_sel6;
   logic [5:0]        out_valid6;
   logic [47:0]       out_data6;
   logic [7:0]        drop_cnt6;

   int unsigned npass = 0;
   int unsigned ntot  = 0;
   int unsigned nfail = 0;

   logic [7:0] sbq [NCH][$];
   int unsigned mdrop = 0;

   always #5 clk = ~clk;

   stream_demux #(.DW(DW), .NCH(NCH), .SELW(SELW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .drop_cnt  (drop_cnt)
   );

   stream_demux #(.DW(8), .NCH(6), .SELW(3)) dut6 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid6),
      .in_ready  (in_ready6),
      .in_data   (in_data6),
      .in_sel    (in_sel6),
      .in_bcast  (1'b0),
      .out_valid (out_valid6),
      .out_ready (6'b0),
      .out_data  (out_data6),
      .drop_cnt  (drop_cnt6)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check the DUT against the scoreboard, then advance one clock and update it.
   task automatic cycle();
      logic [NCH-1:0] ov;
      logic [NCH-1:0] fr;
      logic           rdy;
      logic           bc;
      logic           inr;
      logic           acc;
      #1;
      for (int i = 0; i < NCH; i++) ov[i] = (sbq[i].size() != 0);
      fr  = ~ov | out_ready;
      bc  = BcastEn && in_bcast;
      inr = (in_sel < NCH);
      if (rst) rdy = 1'b0;
      else if (bc) rdy = &fr;
      else if (inr) rdy = fr[in_sel[2:0]];
      else rdy = 1'b1;
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      for (int i = 0; i < NCH; i++) begin
         if (ov[i]) chk($sformatf("data_ch%0d", i), 64'(out_data[i*DW +: DW]), 64'(sbq[i][0]));
      end
      acc = in_valid & rdy;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NCH; i++) sbq[i].delete();
         mdrop = 0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (ov[i] && out_ready[i]) void'(sbq[i].pop_front());
         end
         if (acc) begin
            if (bc) begin
               for (int i = 0; i < NCH; i++) sbq[i].push_back(in_data);
            end else if (inr) begin
               sbq[in_sel[2:0]].push_back(in_data);
            end else if (mdrop != 255) begin
               mdrop++;
            end
         end
      end
      #1;
   endtask

   initial begin
      logic [NCH-1:0] exp_vec;
      logic [7:0]     exp_d1;
      int unsigned    m6;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      in_bcast  = 1'b0;
      out_ready = '0;
      in_valid6 = 1'b0;
      in_data6  = '0;
      in_sel6   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_drop", 64'(drop_cnt), 64'(0));

      // Out-of-range drops on the 6-channel instance, saturating at 255.
      m6 = 0;
      in_valid6 = 1'b1;
      in_sel6   = 3'd7;
      for (int k = 0; k < 300; k++) begin
         in_data6 = 8'($urandom);
         #1;
         chk("d6_in_ready", 64'(in_ready6), 64'(1));
         chk("d6_out_valid", 64'(out_valid6), 64'(0));
         chk("d6_drop", 64'(drop_cnt6), 64'(m6));
         @(posedge clk);
         if (m6 != 255) m6++;
         #1;
      end
      in_valid6 = 1'b0;
      #1;
      chk("d6_drop_sat", 64'(drop_cnt6), 64'(255));

      // Single word to channel 5, consumers stalled.
      in_valid = 1'b1; in_sel = 4'd5; in_data = 8'hA5; out_ready = '0;
      cycle();
      in_valid = 1'b0;
      chk("ov_h20", 64'(out_valid), 64'(8'h20));
      chk("ch5_a5", 64'(out_data[5*DW +: DW]), 64'(8'hA5));
      cycle();
      in_sel = 4'd2;
      cycle();

      // Stall four cycles, then replace with simultaneous drain.
      in_sel = 4'd5;
      repeat (4) cycle();
      chk("ch5_stall", 64'(out_data[5*DW +: DW]), 64'(8'hA5));
      in_valid = 1'b1; in_data = 8'h3C; out_ready = 8'h20;
      cycle();
      in_valid = 1'b0; out_ready = '0;
      chk("ch5_3c", 64'(out_data[5*DW +: DW]), 64'(8'h3C));
      chk("ch5_still_valid", 64'(out_valid[5]), 64'(1));
      cycle();

      // Fill every channel, then count 17 drops.
      in_valid = 1'b1;
      for (int c = 0; c < NCH; c++) begin
         in_sel = SELW'(c); in_data = 8'(8'h10 + c);
         cycle();
      end
      in_sel = 4'd12;
      repeat (17) cycle();
      in_valid = 1'b0;
      chk("full_ff", 64'(out_valid), 64'(8'hFF));
      chk("drop_17", 64'(drop_cnt), 64'(17));

      // Reset mid-traffic: held words are lost, counter cleared.
      rst = 1'b1; in_valid = 1'b1; in_sel = 4'd1;
      cycle();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst2_valid", 64'(out_valid), 64'(0));
      chk("rst2_drop", 64'(drop_cnt), 64'(0));
      chk("rst2_data", 64'(out_data), 64'(0));
      cycle();

      // Broadcast attempt with channel 3 full and stalled.
      in_valid = 1'b1; in_sel = 4'd3; in_data = 8'h33;
      cycle();
      in_bcast = 1'b1; in_sel = 4'd1; in_data = 8'h77;
      cycle();
      out_ready = 8'h08;
      cycle();
      in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
`ifdef STREAM_DEMUX_BCAST_EN
      exp_vec = 8'hFF;
`else
      exp_vec = 8'h02;
`endif
      exp_d1 = 8'h77;
      chk("bcast_valid", 64'(out_valid), 64'(exp_vec));
      chk("bcast_ch1", 64'(out_data[1*DW +: DW]), 64'(exp_d1));
      cycle();
      out_ready = '1;
      cycle();
      out_ready = '0;
      cycle();

      // Random traffic including some out-of-range selects.
      for (int k = 0; k < 10000; k++) begin
         in_valid  = 1'($urandom);
         in_sel    = SELW'($urandom_range(0, 9));
         in_data   = 8'($urandom);
         out_ready = NCH'($urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001: Parameter DW, default 8, data width in bits per channel (1 to 64).
REQ-002: Parameter NCH, default 8, output channel count (2 to 16).
REQ-003: Parameter SELW, default 3, select width; SELW SHALL satisfy 2**SELW >= NCH.
REQ-004: clk  input  1  sole clock, rising edge.
REQ-005: rst  input  1  reset; synchronous, active-high.
REQ-006: in_valid  input  1  input word present.
REQ-007: in_ready  output  1  input word accepted this cycle when in_valid is also high.
REQ-008: in_data  input  DW  input word.
REQ-009: in_sel  input  SELW  target channel index.
REQ-010: in_bcast  input  1  broadcast request (see REQ-030/031).
REQ-011: out_valid  output  NCH  per-channel word present; bit i is channel i.
REQ-012: out_ready  input  NCH  per-channel consumer ready.
REQ-013: out_data  output  NCH*DW  channel i occupies bits [i*DW+DW-1 : i*DW].
REQ-014: drop_cnt  output  8  saturating count of dropped words.

Function
REQ-015: Each channel SHALL have a one-entry holding register (data plus valid flag).
REQ-016: Input transfer: in_valid and in_ready both high on a rising edge.
REQ-017: Output transfer on channel i: out_valid[i] and out_ready[i] both high on a rising edge.
REQ-018: For in-range in_sel, in_ready SHALL equal (!out_valid[in_sel] or out_ready[in_sel]), combinationally.
REQ-019: in_ready SHALL NOT depend on in_valid.
REQ-020: An accepted word SHALL appear on out_data of channel in_sel with out_valid set on the next cycle; latency is exactly 1 clock.
REQ-021: A simultaneous input transfer and output transfer on the same channel SHALL replace the held word; out_valid stays 1 and the new word is visible next cycle, giving full throughput.
REQ-022: An output transfer with no new input SHALL clear out_valid[i] on the next cycle.
REQ-023: While out_valid[i]=1 and out_ready[i]=0, out_data for channel i SHALL hold stable.
REQ-024: Channels not addressed SHALL be unaffected by input traffic.
REQ-025: Out-of-range in_sel (in_sel >= NCH) SHALL force in_ready=1; the word is discarded and no out_valid changes.
REQ-026: Each discarded word SHALL increment drop_cnt by 1, saturating at 255 with no wrap.
REQ-027: out_data of an invalid channel SHALL hold its last loaded value and SHALL NOT be checked by the bench.
REQ-028: out_valid SHALL depend only on registered state and never on out_ready.

Reset
REQ-029: On rst=1 at a rising edge, all out_valid SHALL be 0, all holding data 0 and drop_cnt 0 in the next cycle. While rst is high, no transfers occur and in_ready SHALL be 0. A word held mid-handshake at reset SHALL be lost without counting as a drop.

Configuration
REQ-030: Macro STREAM_DEMUX_BCAST_EN defined: when in_bcast=1, in_ready SHALL be the AND over all channels of (!out_valid[i] or out_ready[i]); on transfer, every channel loads in_data. in_sel is ignored and no drop is counted.
REQ-031: Macro STREAM_DEMUX_BCAST_EN undefined: in_bcast SHALL be ignored (treated as 0), and the port SHALL remain present.

Verification
REQ-032: DW=8, NCH=8: reset, then in_sel=5 and in_data=0xA5 for one cycle with out_ready all 0 -> out_valid=8'h20 next cycle, channel 5 data 0xA5, in_ready=0 for sel=5 and 1 for sel=2.
REQ-033: Stall then drain on channel 5: hold out_ready[5]=0 for 4 cycles -> data stays 0xA5; send 0x3C with out_ready[5]=1 -> next cycle data 0x3C, out_valid[5] still 1.
REQ-034: NCH=6, in_sel=7 for 300 cycles -> in_ready=1 throughout, out_valid=0, drop_cnt=255 with no wrap.
REQ-035: Random in_valid, in_sel and out_ready over 10k cycles -> scoreboard per channel shows no loss, duplication or reordering, and one-cycle latency on an empty slot.
REQ-036: rst pulsed while out_valid=8'hFF and drop_cnt=17 -> next cycle out_valid=0, drop_cnt=0, in_ready=0 during rst.
REQ-037: STREAM_DEMUX_BCAST_EN defined, channel 3 full and stalled, in_bcast=1 with 0x77 -> in_ready=0; release out_ready[3] -> all 8 channels show 0x77 next cycle; macro undefined, same stimulus with in_sel=1 -> only channel 1 loads.
